// File: rtl/aibio_cdr_pkg.sv
// aibio_cdr_pkg: shared FSM/direction types and averaging-window decode for the CDR phase controller.
package aibio_cdr_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_UPDATE = 2'd2} cdr_state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} cdr_dir_t;
  function automatic logic [5:0] avg_win(input logic [1:0] sel);
    return 6'd4 << sel;
  endfunction
endpackage

// File: rtl/aibio_cdr_sync.sv
// aibio_cdr_sync: multi-flop synchronizer for the asynchronous phase-detector sample.
module aibio_cdr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_sync <= '0;
    else r_sync <= (r_sync << 1) | SYNC_STAGES'(i_d);
  end
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/aibio_cdr_phase_ctrl.sv
// aibio_cdr_phase_ctrl: bang-bang CDR loop that averages phase-detector votes per window and steps the PI code.
module aibio_cdr_phase_ctrl
  import aibio_cdr_pkg::*;
#(
  parameter int CODE_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              vddcq,
  input  logic              vss,
  input  logic              i_cdr_phdet,
  input  logic              i_cdr_en,
  input  logic [1:0]        i_avg_sel,
  input  logic [3:0]        i_deadband,
  input  logic [CODE_W-1:0] i_pi_code_init,
  output logic [CODE_W-1:0] o_pi_code,
  output logic              o_pi_code_vld,
  output logic              o_cdr_lock
);
  localparam int LW = $clog2(LOCK_CNT + 1);
  cdr_state_t        r_state;
  cdr_dir_t          r_prev;
  cdr_dir_t          w_dec;
  logic [5:0]        r_w, r_cnt, r_ones, w_half;
  logic [LW-1:0]     r_lock_cnt, w_lock_inc, w_lock_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic              r_lock, w_ph_s, w_up, w_dn;
  logic              w_unused;
  assign w_unused = ^{vddcq, vss};
  aibio_cdr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_cdr_phdet),
    .o_q    (w_ph_s)
  );
  // Widened compares keep ones+deadband and W/2+deadband free of wrap/underflow
  assign w_half     = {1'b0, r_w[5:1]};
  assign w_up       = 7'(r_ones) > 7'(w_half) + 7'(i_deadband);
  assign w_dn       = 7'(r_ones) + 7'(i_deadband) < 7'(w_half);
  assign w_dec      = w_up ? DIR_UP : w_dn ? DIR_DOWN : DIR_NONE;
  assign w_code_nxt = w_dec == DIR_UP ? r_code + CODE_W'(1) : w_dec == DIR_DOWN ? r_code - CODE_W'(1) : r_code;
  assign w_lock_inc = r_lock_cnt == LW'(LOCK_CNT) ? r_lock_cnt : r_lock_cnt + LW'(1);
  assign w_lock_nxt = (w_dec == DIR_NONE || (r_prev != DIR_NONE && w_dec != r_prev)) ? w_lock_inc :
                      w_dec == r_prev ? '0 : r_lock_cnt;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_prev     <= DIR_NONE;
      r_w        <= '0;
      r_cnt      <= '0;
      r_ones     <= '0;
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
      r_code     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_cdr_en) begin
          r_state <= ST_ACCUM;
          r_code  <= i_pi_code_init;
          r_prev  <= DIR_NONE;
          r_w     <= avg_win(i_avg_sel);
          r_cnt   <= '0;
          r_ones  <= '0;
        end
        ST_ACCUM: if (!i_cdr_en) begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
          r_lock     <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + 6'd1;
          r_ones <= r_ones + 6'(w_ph_s);
          if (r_cnt == r_w - 6'd1) r_state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_code     <= w_code_nxt;
          r_prev     <= w_dec != DIR_NONE ? w_dec : r_prev;
          r_lock_cnt <= i_cdr_en ? w_lock_nxt : '0;
          r_lock     <= i_cdr_en && w_lock_nxt == LW'(LOCK_CNT);
          r_state    <= i_cdr_en ? ST_ACCUM : ST_IDLE;
          r_w        <= avg_win(i_avg_sel);
          r_cnt      <= '0;
          r_ones     <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign o_pi_code     = r_code;
  assign o_pi_code_vld = r_state == ST_UPDATE;
  assign o_cdr_lock    = r_lock;
endmodule

// File: tb/tb_aibio_cdr_phase_ctrl.sv
// tb_aibio_cdr_phase_ctrl: directed and random stimulus checked each cycle against a window-level loop model.
module tb_aibio_cdr_phase_ctrl;
  localparam int CW = 7;
  localparam int NC = 1 << CW;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst = 1'b1, en = 1'b0, ph = 1'b0;
  logic [1:0]    sel = '0;
  logic [3:0]    db = '0;
  logic [CW-1:0] init = '0;
  logic [CW-1:0] code;
  logic          vld, lock;
  aibio_cdr_phase_ctrl dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .vddcq         (1'b1),
    .vss           (1'b0),
    .i_cdr_phdet   (ph),
    .i_cdr_en      (en),
    .i_avg_sel     (sel),
    .i_deadband    (db),
    .i_pi_code_init(init),
    .o_pi_code     (code),
    .o_pi_code_vld (vld),
    .o_cdr_lock    (lock)
  );
  int n_tot = 0, n_bad = 0;
  task automatic check(input string tag, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask
  // Stimulus settings applied at the next cycle; mode 0/1 constant, 2 alternating, 3 biased random
  logic s_rst = 1'b1, s_en = 1'b0;
  int s_mode = 0, s_p = 50, s_sel = 0, s_db = 0, s_init = 0;
  bit ph_hist [0:8191];
  int cyc = 0, r0 = 0;
  int m_code = 0, m_prev = 0, m_lock = 0, m_act = 0, m_upd = 0, m_w = 4;
  int n_vld = 0, last_vld = -1, gap = 0;
  function automatic int phs(input int x);
    return (x - 2 >= r0) ? int'(ph_hist[x-2]) : 0;
  endfunction
  task automatic step();
    int ones, half, d;
    @(posedge clk);
    #1;
    rst  = s_rst;
    en   = s_en;
    sel  = 2'(s_sel);
    db   = 4'(s_db);
    init = CW'(s_init);
    ph   = s_mode == 0 ? 1'b0 : s_mode == 1 ? 1'b1 : s_mode == 2 ? cyc[0] : ($urandom_range(0, 99) < s_p);
    ph_hist[cyc] = ph;
    @(negedge clk);
    if (rst) begin
      m_code = 0; m_prev = 0; m_lock = 0; m_act = 0; r0 = cyc + 1;
    end
    check("vld", vld, int'(m_act == 1 && cyc == m_upd));
    check("code", code, m_code);
    check("lock", lock, int'(m_lock == 15));
    if (vld) begin
      n_vld++;
      if (last_vld >= 0) gap = cyc - last_vld;
      last_vld = cyc;
    end
    if (!rst) begin
      if (m_act == 0) begin
        if (en) begin
          m_act = 1; m_code = int'(init); m_prev = 0; m_w = 4 << sel; m_upd = cyc + m_w + 1;
        end
      end else if (cyc < m_upd) begin
        if (!en) begin m_act = 0; m_lock = 0; end
      end else begin
        ones = 0;
        for (int x = m_upd - m_w; x < m_upd; x++) ones += phs(x);
        half = m_w / 2;
        d = ones > half + int'(db) ? 1 : ones + int'(db) < half ? 2 : 0;
        m_code = d == 1 ? (m_code + 1) % NC : d == 2 ? (m_code + NC - 1) % NC : m_code;
        if (d == 0 || (m_prev != 0 && d != m_prev)) m_lock = m_lock < 15 ? m_lock + 1 : 15;
        else if (d == m_prev) m_lock = 0;
        if (d != 0) m_prev = d;
        if (en) begin m_w = 4 << sel; m_upd = cyc + m_w + 1; end
        else begin m_act = 0; m_lock = 0; end
      end
    end
    cyc++;
  endtask
  initial begin
    int k;
    repeat (2) step();
    check("rst_code_lit", code, 0);
    check("rst_vld_lit", vld, 0);
    // Wrap-around upward: W=8, ph=1, init=126
    s_rst = 1'b0; s_mode = 1; s_sel = 1; s_db = 0; s_init = 126;
    repeat (3) step();
    s_en = 1'b1; n_vld = 0; last_vld = -1;
    repeat (29) step();
    check("wrap_code", code, 1);
    check("wrap_nvld", n_vld, 3);
    check("wrap_gap", gap, 9);
    // Wrap-around downward: W=4, ph=0, init=0
    s_en = 1'b0;
    repeat (2) step();
    s_mode = 0; s_sel = 0; s_init = 0;
    repeat (3) step();
    s_en = 1'b1; n_vld = 0; last_vld = -1;
    repeat (12) step();
    check("down_code", code, 126);
    check("down_nvld", n_vld, 2);
    check("down_gap", gap, 5);
    // Deadband hold and lock: W=16, db=2, alternating ph
    s_en = 1'b0;
    repeat (2) step();
    s_mode = 2; s_sel = 2; s_db = 2; s_init = 50;
    repeat (3) step();
    s_en = 1'b1; n_vld = 0;
    repeat (256) step();
    check("hold_code", code, 50);
    check("hold_nvld", n_vld, 15);
    check("lock_pre", lock, 0);
    step();
    check("lock_up", lock, 1);
    // Switch to W=8 mid-window, stay locked, then lose lock with ph=1
    s_sel = 1;
    repeat (34) step();
    check("lock_w8", lock, 1);
    s_mode = 1; s_db = 0;
    repeat (27) step();
    check("lol_lock", lock, 0);
    check("lol_code", code, 52);
    // Abort in the 5th ACCUM cycle
    k = 0;
    while (!vld && k < 40) begin step(); k++; end
    check("abort_wait", vld, 1);
    repeat (4) step();
    s_en = 1'b0;
    step();
    n_vld = 0;
    repeat (6) step();
    check("abort_nvld", n_vld, 0);
    check("abort_code", code, 53);
    check("abort_lock", lock, 0);
    s_init = 40; s_en = 1'b1;
    repeat (2) step();
    check("reinit_code", code, 40);
    // Reset mid-window
    repeat (5) step();
    s_rst = 1'b1;
    step();
    check("rst_mid_code", code, 0);
    check("rst_mid_vld", vld, 0);
    check("rst_mid_lock", lock, 0);
    s_rst = 1'b0; s_en = 1'b0;
    repeat (2) step();
    // Randomized operation
    s_mode = 3;
    repeat (3000) begin
      s_rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 299) == 0) s_en = 1'b0;
      else if (!s_en && $urandom_range(0, 3) == 0) s_en = 1'b1;
      if ($urandom_range(0, 49) == 0) s_sel = int'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) s_db = int'($urandom_range(0, 4));
      if ($urandom_range(0, 59) == 0) s_p = $urandom_range(0, 2) == 0 ? 10 : $urandom_range(0, 1) == 0 ? 50 : 90;
      s_init = int'($urandom_range(0, NC - 1));
      step();
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/aibio_cdr_phase_ctrl.md
AIBIO_CDR_PHASE_CTRL -- requirements
Module: aibio_cdr_phase_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 7: phase-interpolator code width; the code space is 2**CODE_W and circular.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on i_cdr_phdet.
REQ-003 SHALL have parameter LOCK_CNT, default 15: number of qualifying windows required to assert lock.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning. The clock and reset come first.
- i_clk  input  1  single block clock (divided PI clock domain).
- i_reset  input  1  asynchronous, active-high reset.
- vddcq  input  1  supply.
- vss  input  1  ground.
- i_cdr_phdet  input  1  phase-detector sample; asynchronous to i_clk; 1 = data clock late, so step the code up.
- i_cdr_en  input  1  loop enable.
- i_avg_sel  input  2  window W: 00=4, 01=8, 10=16, 11=32 samples.
- i_deadband  input  4  hysteresis around W/2.
- i_pi_code_init  input  CODE_W  code loaded on enable.
- o_pi_code  output  CODE_W  PI code.
- o_pi_code_vld  output  1  one-cycle pulse on each UPDATE.
- o_cdr_lock  output  1  lock indicator.

Function
REQ-005 SHALL pass i_cdr_phdet through a SYNC_STAGES flop synchronizer; every use of the phdet below refers to the synchronized value ph_s.
REQ-006 SHALL implement the FSM IDLE, ACCUM, UPDATE.
- IDLE -> ACCUM when i_cdr_en=1.
- ACCUM -> UPDATE after W sampled cycles.
- UPDATE -> ACCUM after one cycle.
REQ-007 SHALL load o_pi_code <= i_pi_code_init on the IDLE->ACCUM transition, and clear the ones counter and the previous-direction register (set to NONE).
REQ-008 SHALL, in ACCUM, count sample cycles (6 bits) and ones = number of cycles with ph_s=1 (6 bits, max 32).
REQ-009 SHALL sample i_avg_sel only on entry to ACCUM; a change mid-window takes effect from the next window.
REQ-010 SHALL make the decision at UPDATE using unsigned compares with no underflow:
- UP if ones > W/2 + i_deadband.
- DOWN if ones + i_deadband < W/2.
- HOLD otherwise.
REQ-011 SHALL apply the decision at UPDATE:
- UP: o_pi_code + 1, wrapping 2**CODE_W-1 -> 0.
- DOWN: o_pi_code - 1, wrapping 0 -> 2**CODE_W-1.
- HOLD: o_pi_code unchanged.
REQ-012 SHALL assert o_pi_code_vld for exactly the UPDATE cycle, including HOLD decisions; the new o_pi_code is visible on the cycle after UPDATE.
REQ-013 SHALL discard the ph_s sample in the UPDATE cycle; the window period is W+1 cycles.
REQ-014 SHALL maintain a lock counter (saturating at LOCK_CNT), updated at UPDATE:
- HOLD, or a step opposite to the previous non-HOLD direction: increment the counter.
- A step equal to the previous non-HOLD direction: clear the counter.
- A first step after NONE: counter unchanged.
- Any non-HOLD step sets the previous-direction register.
REQ-015 SHALL drive o_cdr_lock = (lock counter == LOCK_CNT) from a register; a clear at UPDATE deasserts o_cdr_lock on the following cycle.
REQ-016 SHALL, if i_cdr_en falls in ACCUM or UPDATE, go to IDLE on the next edge:
- Discard the partial window; no update is applied.
- Hold o_pi_code.
- Clear o_pi_code_vld, o_cdr_lock and the lock counter.
REQ-017 SHALL give UPDATE priority when i_cdr_en falls in the UPDATE cycle: the update completes, and the block then enters IDLE.

Reset
REQ-018 SHALL, while i_reset=1 (asynchronous), set:
- FSM = IDLE.
- o_pi_code = 0, o_pi_code_vld = 0, o_cdr_lock = 0.
- All counters, the synchronizer flops and the previous-direction register = 0 / NONE.
REQ-019 SHALL, on i_reset mid-window, abort the window with no pulse on o_pi_code_vld; operation resumes via IDLE only after i_reset=0 and i_cdr_en=1.

Structure
REQ-020 SHALL place the FSM state enum, the direction enum (NONE/UP/DOWN) and the i_avg_sel-to-W decode function in shared package aibio_cdr_pkg.
REQ-021 SHALL implement the synchronizer as sub-module aibio_cdr_sync (parameter SYNC_STAGES, async active-high reset), instantiated once.

Verification
REQ-022 Settle, wrap-around and deadband:
- W=8, db=0, ph=1 constant, init=126 -> code 127, then 0, then 1 on successive UPDATEs; o_pi_code_vld pulses every 9 cycles.
- W=4, db=0, ph=0 constant, init=0 -> code steps to 127, then 126.
- W=16, db=2, ph alternating 1/0 (ones=8) -> HOLD every window; o_pi_code_vld pulses, code unchanged; o_cdr_lock rises after 15 windows.
REQ-023 Loss of lock: locked at W=8; ph=1 constant for 2 windows -> code steps up twice, and the second step clears lock so that o_cdr_lock falls one cycle after the second UPDATE.
REQ-024 Abort:
- Deassert i_cdr_en in the 5th ACCUM cycle -> no o_pi_code_vld; code held; o_cdr_lock=0.
- Re-enable with init=40 -> code=40.
- Assert i_reset mid-window -> all outputs 0 immediately.
